sh4a_mac_seq: RTL

Initiator-side sequencer for the SH4A multiply-accumulate unit (`sh4a_mac`). Owns the MACH/MACL architectural registers, executes MAC.W/MAC.L by fetching both memory operands, driving the MAC unit's operand ports with sign-corrected values, and writing back the optionally saturated result. Sits between the integer pipeline (start/done handshake) and the data-memory read port.

---
 rtl/sh4a_mac_pkg.sv | 26 ++
 rtl/sh4a_mac_sat.sv | 46 ++++
 rtl/sh4a_mac_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sh4a_mac_pkg.sv
// Shared types and constants for the SH4A MAC sequencer: FSM state encoding,
// register post-increment amounts and the signed saturation bounds.
package sh4a_mac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_N = 3'd1,
        ST_RD_M = 3'd2,
        ST_EXEC = 3'd3,
        ST_WAIT = 3'd4,
        ST_WB   = 3'd5
    } state_e;

    // Post-increment applied to Rn/Rm by the pipeline after the op.
    localparam logic [2:0] INC_W = 3'd2;
    localparam logic [2:0] INC_L = 3'd4;

    // MAC.L saturation: signed 48-bit range, sign-extended to 64 bits.
    localparam logic signed [63:0] SAT48_MIN = 64'shFFFF_8000_0000_0000;
    localparam logic signed [63:0] SAT48_MAX = 64'sh0000_7FFF_FFFF_FFFF;

    // MAC.W saturation: signed 32-bit range, sign-extended to 64 bits.
    localparam logic signed [63:0] SAT32_MIN = 64'shFFFF_FFFF_8000_0000;
    localparam logic signed [63:0] SAT32_MAX = 64'sh0000_0000_7FFF_FFFF;

endpackage

// File: rtl/sh4a_mac_sat.sv
// Combinational writeback clamp for the MAC sequencer. Only instantiated when
// SH4A_MAC_SAT_EN is defined. With s_bit clear the raw 64-bit result passes
// through; MAC.L clamps to signed 48 bits, MAC.W clamps to signed 32 bits
// into MACL and leaves MACH untouched.
module sh4a_mac_sat
    import sh4a_mac_pkg::*;
(
    input  logic [63:0] result_i,
    input  logic        op_long_i,
    input  logic        s_bit_i,
    input  logic [31:0] mach_i,
    output logic [31:0] mach_o,
    output logic [31:0] macl_o
);

    function automatic logic signed [63:0] clamp(
        input logic signed [63:0] v,
        input logic signed [63:0] lo,
        input logic signed [63:0] hi
    );
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    logic signed [63:0] clamped;

    // Select pass-through, 48-bit clamp or 32-bit clamp for the new MACH/MACL.
    always_comb begin
        clamped = result_i;
        mach_o  = result_i[63:32];
        macl_o  = result_i[31:0];
        if (s_bit_i) begin
            if (op_long_i) begin
                clamped = clamp(result_i, SAT48_MIN, SAT48_MAX);
                mach_o  = clamped[63:32];
                macl_o  = clamped[31:0];
            end else begin
                clamped = clamp(result_i, SAT32_MIN, SAT32_MAX);
                mach_o  = mach_i;
                macl_o  = clamped[31:0];
            end
        end
    end

endmodule

// File: rtl/sh4a_mac_seq.sv
// SH4A MAC.W/MAC.L initiator-side sequencer. Owns MACH/MACL, fetches both
// memory operands, drives the external multiply-accumulate unit with
// sign-corrected operands and writes the result back.
// Optional feature: define SH4A_MAC_SAT_EN to honour SR.S saturation;
// without it s_bit is ignored and every op wraps in the full 64 bits.
module sh4a_mac_seq
    import sh4a_mac_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op_long,
    input  logic        s_bit,
    input  logic [31:0] rn_addr,
    input  logic [31:0] rm_addr,
    input  logic        clrmac,
    input  logic        mach_we,
    input  logic        macl_we,
    input  logic [31:0] wdata,
    output logic [31:0] mach,
    output logic [31:0] macl,
    output logic        busy,
    output logic        done,
    output logic [2:0]  rn_inc,
    output logic [2:0]  rm_inc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_long,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mul_src1,
    output logic [31:0] mul_src2,
    output logic [63:0] add_src1,
    output logic [63:0] add_src2,
    input  logic [63:0] mac_result
);

    state_e      state_q, state_d;
    logic [31:0] rn_q, rm_q;
    logic        long_q;
    logic [31:0] opa_q, opb_q;
    logic [63:0] res_q;
    logic [31:0] mach_q, macl_q;

    logic [31:0] rd_ext;
    logic [63:0] corr;
    logic [63:0] acc;
    logic        acc_sext;
    logic [31:0] wb_mach, wb_macl;

`ifdef SH4A_MAC_SAT_EN
    logic sat_q;

    // Latch the saturation mode together with the launching start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else if (state_q == ST_IDLE && start) begin
            sat_q <= s_bit;
        end
    end

    sh4a_mac_sat u_sat (
        .result_i  (res_q),
        .op_long_i (long_q),
        .s_bit_i   (sat_q),
        .mach_i    (mach_q),
        .mach_o    (wb_mach),
        .macl_o    (wb_macl)
    );

    // MAC.W in saturating mode accumulates onto MACL alone.
    assign acc_sext = ~long_q & sat_q;
`else
    // s_bit has no effect in this build.
    logic unused_s_bit;
    assign unused_s_bit = s_bit;

    assign wb_mach  = res_q[63:32];
    assign wb_macl  = res_q[31:0];
    assign acc_sext = 1'b0;
`endif

    // MAC.W reads return 16 bits in [15:0]; sign-extend them to 32.
    assign rd_ext = long_q ? mem_rdata : {{16{mem_rdata[15]}}, mem_rdata[15:0]};
    assign acc    = acc_sext ? {{32{macl_q[31]}}, macl_q} : {mach_q, macl_q};
    assign mach   = mach_q;
    assign macl   = macl_q;

    // Turn the unsigned 32x32 product into a signed one: subtract B<<32 when A
    // is negative and A<<32 when B is negative (mod 2^64).
    always_comb begin
        corr = 64'd0;
        if (opa_q[31]) corr = corr - {opb_q, 32'd0};
        if (opb_q[31]) corr = corr - {opa_q, 32'd0};
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: reads stall on mem_ack, MAC unit takes EXEC+WAIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)   state_d = ST_RD_N;
            ST_RD_N: if (mem_ack) state_d = ST_RD_M;
            ST_RD_M: if (mem_ack) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WAIT;
            ST_WAIT: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from state so reset drops them immediately.
    always_comb begin
        busy     = (state_q != ST_IDLE);
        done     = 1'b0;
        rn_inc   = 3'd0;
        rm_inc   = 3'd0;
        mem_req  = 1'b0;
        mem_addr = 32'd0;
        mem_long = 1'b0;
        mul_src1 = 32'd0;
        mul_src2 = 32'd0;
        add_src1 = 64'd0;
        add_src2 = 64'd0;
        case (state_q)
            ST_RD_N: begin
                mem_req  = 1'b1;
                mem_addr = rn_q;
                mem_long = long_q;
            end
            ST_RD_M: begin
                mem_req  = 1'b1;
                mem_addr = rm_q;
                mem_long = long_q;
            end
            ST_EXEC, ST_WAIT: begin
                mul_src1 = opa_q;
                mul_src2 = opb_q;
                add_src1 = acc;
                add_src2 = corr;
            end
            ST_WB: begin
                done   = 1'b1;
                rn_inc = long_q ? INC_L : INC_W;
                rm_inc = long_q ? INC_L : INC_W;
            end
            default: ;
        endcase
    end

    // Architectural registers, latched operands and MAC result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rn_q   <= 32'd0;
            rm_q   <= 32'd0;
            long_q <= 1'b0;
            opa_q  <= 32'd0;
            opb_q  <= 32'd0;
            res_q  <= 64'd0;
            mach_q <= 32'd0;
            macl_q <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clrmac) begin
                        mach_q <= 32'd0;
                        macl_q <= 32'd0;
                    end else begin
                        if (mach_we) mach_q <= wdata;
                        if (macl_we) macl_q <= wdata;
                    end
                    if (start) begin
                        rn_q   <= rn_addr;
                        rm_q   <= rm_addr;
                        long_q <= op_long;
                    end
                end
                ST_RD_N: if (mem_ack) opa_q <= rd_ext;
                ST_RD_M: if (mem_ack) opb_q <= rd_ext;
                ST_WAIT: res_q <= mac_result;
                ST_WB: begin
                    mach_q <= wb_mach;
                    macl_q <= wb_macl;
                end
                default: ;
            endcase
        end
    end

endmodule
